// File: rtl/holy_core_pkg.sv
// Shared types for the Holy Core memory subsystem.
// holy_dm_cache_state_t : FSM state of the multi-line direct-mapped data cache,
//                         exported so the AXI arbiter can see what the cache is doing.
// merge_bytes           : byte-lane merge used by store hits.
package holy_core_pkg;

    typedef enum logic [2:0] {
        DM_IDLE,
        DM_WB_REQ,
        DM_WB_DATA,
        DM_WB_RESP,
        DM_RF_REQ,
        DM_RF_DATA,
        DM_FLUSH_SCAN
    } holy_dm_cache_state_t;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        return r;
    endfunction

endpackage

// File: rtl/axi_if.sv
// AXI4 bundle between a cache (master) and the arbiter (slave).
// 32-bit address and data, 4-bit ids; only the fields the cache uses.
interface axi_if;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );
endinterface

// File: rtl/holy_dm_cache_meta.sv
// Per-line metadata (tag, valid, dirty) for holy_dm_cache.
// Ports: clk/rst (sync, active high; clears valid+dirty only),
//        rd_idx_i -> rd_tag_o/rd_valid_o/rd_dirty_o (asynchronous read),
//        we_i/wr_idx_i/wr_tag_i/wr_valid_i/wr_dirty_i (single write port, full-entry write).
module holy_dm_cache_meta #(
    parameter int NUM_LINES = 4,
    parameter int IW        = 2,
    parameter int TW        = 23
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] rd_idx_i,
    output logic [TW-1:0] rd_tag_o,
    output logic          rd_valid_o,
    output logic          rd_dirty_o,
    input  logic          we_i,
    input  logic [IW-1:0] wr_idx_i,
    input  logic [TW-1:0] wr_tag_i,
    input  logic          wr_valid_i,
    input  logic          wr_dirty_i
);
    logic [TW-1:0]        tag_q [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx_i] <= wr_valid_i;
            dirty_q[wr_idx_i] <= wr_dirty_i;
        end
    end

    // Tags are meaningless while valid is clear, so they need no reset.
    always_ff @(posedge clk) begin
        if (we_i) tag_q[wr_idx_i] <= wr_tag_i;
    end

    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_dirty_o = dirty_q[rd_idx_i];
endmodule

// File: rtl/holy_dm_cache.sv
// Multi-line write-back direct-mapped data cache for the Holy Core.
// Core side : address/write_data/read_enable/write_enable/byte_enable in,
//             read_data (combinational on hit) and cache_stall out.
// Control   : flush_req (level) / flush_done (pulse), sticky axi_error.
// Memory    : axi (AXI4 master, one LINE_WORDS-beat INCR burst per refill/evict).
// Debug     : cache_state, the current FSM state for the arbiter.
module holy_dm_cache
    import holy_core_pkg::*;
#(
    parameter int NUM_LINES  = 4,
    parameter int LINE_WORDS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          address,
    input  logic [31:0]          write_data,
    input  logic                 read_enable,
    input  logic                 write_enable,
    input  logic [3:0]           byte_enable,
    output logic [31:0]          read_data,
    output logic                 cache_stall,
    input  logic                 flush_req,
    output logic                 flush_done,
    output logic                 axi_error,
    axi_if.master                axi,
    output holy_dm_cache_state_t cache_state
);
    localparam int OB = $clog2(LINE_WORDS);
    localparam int IB = $clog2(NUM_LINES);
    localparam int IW = (IB > 0) ? IB : 1;
    localparam int TW = 30 - OB - IB;
    localparam int BW = OB + 1;   // one spare bit so the beat count can reach LINE_WORDS

    holy_dm_cache_state_t state_q, state_d;
    logic [IW-1:0] line_q, line_d;
    logic [IW:0]   scan_q, scan_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [TW-1:0] rtag_q, rtag_d;
    logic          flush_q, flush_d;
    logic          err_q, err_d;

    logic [31:0]   data_q [NUM_LINES*LINE_WORDS];

    // Address split
    logic [31:0]   idx_sh, tag_sh;
    logic [OB-1:0] req_off;
    logic [IW-1:0] req_idx;
    logic [TW-1:0] req_tag;
    assign idx_sh  = address >> (OB + 2);
    assign tag_sh  = address >> (OB + 2 + IB);
    assign req_off = address[OB+1:2];
    assign req_idx = idx_sh[IW-1:0] & IW'(NUM_LINES - 1);
    assign req_tag = tag_sh[TW-1:0];

    function automatic logic [31:0] line_addr(input logic [TW-1:0] t, input logic [IW-1:0] i);
        return (32'(t) << (OB + 2 + IB)) | ((32'(i) & 32'(NUM_LINES - 1)) << (OB + 2));
    endfunction

    // Metadata: in IDLE we look up the request line, while scanning the scan
    // pointer, and during a burst the latched victim/refill line.
    logic [IW-1:0] m_rd_idx, m_wr_idx;
    logic [TW-1:0] m_tag, m_wr_tag;
    logic          m_valid, m_dirty, m_we, m_wr_valid, m_wr_dirty;

    assign m_rd_idx = (state_q == DM_IDLE)       ? req_idx :
                      (state_q == DM_FLUSH_SCAN) ? scan_q[IW-1:0] : line_q;

    holy_dm_cache_meta #(.NUM_LINES(NUM_LINES), .IW(IW), .TW(TW)) u_meta (
        .clk        (clk),
        .rst        (rst),
        .rd_idx_i   (m_rd_idx),
        .rd_tag_o   (m_tag),
        .rd_valid_o (m_valid),
        .rd_dirty_o (m_dirty),
        .we_i       (m_we),
        .wr_idx_i   (m_wr_idx),
        .wr_tag_i   (m_wr_tag),
        .wr_valid_i (m_wr_valid),
        .wr_dirty_i (m_wr_dirty)
    );

    logic we_eff, access, hit;
    assign we_eff = write_enable & |byte_enable;
    assign access = read_enable | we_eff;
    assign hit    = (state_q == DM_IDLE) & m_valid & (m_tag == req_tag);

    logic [IW+OB-1:0] req_word;
    assign req_word = {req_idx, req_off};

    assign read_data   = (hit & read_enable & ~we_eff) ? data_q[req_word] : 32'h0;
    assign cache_stall = (state_q != DM_IDLE) | (~hit & access) |
                         ((state_q == DM_IDLE) & flush_req & ~access);
    assign axi_error   = err_q;
    assign cache_state = state_q;

    // Fixed AXI fields; addresses depend only on registered state so they
    // stay stable under backpressure.
    assign axi.awid    = '0;
    assign axi.awaddr  = line_addr(m_tag, line_q);
    assign axi.awlen   = 8'(LINE_WORDS - 1);
    assign axi.awsize  = AXI_SIZE_4B;
    assign axi.awburst = AXI_BURST_INCR;
    assign axi.wstrb   = 4'hF;
    assign axi.wdata   = data_q[{line_q, beat_q[OB-1:0]}];
    assign axi.wlast   = (state_q == DM_WB_DATA) && (beat_q == BW'(LINE_WORDS - 1));
    assign axi.arid    = '0;
    assign axi.araddr  = line_addr(rtag_q, line_q);
    assign axi.arlen   = 8'(LINE_WORDS - 1);
    assign axi.arsize  = AXI_SIZE_4B;
    assign axi.arburst = AXI_BURST_INCR;

    logic             d_we;
    logic [IW+OB-1:0] d_widx;
    logic [31:0]      d_wdata;

    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        scan_d      = scan_q;
        beat_d      = beat_q;
        rtag_d      = rtag_q;
        flush_d     = flush_q;
        err_d       = err_q;
        m_we        = 1'b0;
        m_wr_idx    = line_q;
        m_wr_tag    = m_tag;
        m_wr_valid  = m_valid;
        m_wr_dirty  = m_dirty;
        d_we        = 1'b0;
        d_widx      = req_word;
        d_wdata     = axi.rdata;
        flush_done  = 1'b0;
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        axi.bready  = 1'b0;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;

        unique case (state_q)
            DM_IDLE: begin
                if (access) begin
                    if (hit) begin
                        if (we_eff) begin
                            d_we       = 1'b1;
                            d_wdata    = merge_bytes(data_q[req_word], write_data, byte_enable);
                            m_we       = 1'b1;
                            m_wr_idx   = req_idx;
                            m_wr_tag   = req_tag;
                            m_wr_valid = 1'b1;
                            m_wr_dirty = 1'b1;
                        end
                    end else begin
                        line_d  = req_idx;
                        rtag_d  = req_tag;
                        flush_d = 1'b0;
                        state_d = (m_valid & m_dirty) ? DM_WB_REQ : DM_RF_REQ;
                    end
                end else if (flush_req) begin
                    scan_d  = '0;
                    flush_d = 1'b1;
                    state_d = DM_FLUSH_SCAN;
                end
            end
            DM_FLUSH_SCAN: begin
                if (scan_q == (IW+1)'(NUM_LINES)) begin
                    flush_done = 1'b1;
                    flush_d    = 1'b0;
                    state_d    = DM_IDLE;
                end else if (m_valid & m_dirty) begin
                    line_d  = scan_q[IW-1:0];
                    state_d = DM_WB_REQ;
                end else begin
                    scan_d = scan_q + 1'b1;
                end
            end
            DM_WB_REQ: begin
                axi.awvalid = 1'b1;
                if (axi.awready) begin
                    beat_d  = '0;
                    state_d = DM_WB_DATA;
                end
            end
            DM_WB_DATA: begin
                axi.wvalid = 1'b1;
                if (axi.wready) begin
                    if (axi.wlast) state_d = DM_WB_RESP;
                    else           beat_d  = beat_q + 1'b1;
                end
            end
            DM_WB_RESP: begin
                axi.bready = 1'b1;
                if (axi.bvalid) begin
                    m_we       = 1'b1;
                    m_wr_dirty = 1'b0;
                    if (axi.bresp != 2'b00) err_d = 1'b1;
                    if (flush_q) begin
                        scan_d  = scan_q + 1'b1;
                        state_d = DM_FLUSH_SCAN;
                    end else begin
                        state_d = DM_RF_REQ;
                    end
                end
            end
            DM_RF_REQ: begin
                axi.arvalid = 1'b1;
                if (axi.arready) begin
                    beat_d  = '0;
                    state_d = DM_RF_DATA;
                end
            end
            DM_RF_DATA: begin
                axi.rready = 1'b1;
                if (axi.rvalid) begin
                    // Beats beyond LINE_WORDS are dropped; the short/long burst
                    // is caught on rlast by the beat count.
                    if (!beat_q[OB]) begin
                        d_we   = 1'b1;
                        d_widx = {line_q, beat_q[OB-1:0]};
                    end
                    if (axi.rlast) begin
                        m_we       = 1'b1;
                        m_wr_tag   = rtag_q;
                        m_wr_dirty = 1'b0;
                        m_wr_valid = (beat_q == BW'(LINE_WORDS - 1));
                        if (beat_q != BW'(LINE_WORDS - 1)) err_d = 1'b1;
                        state_d = DM_IDLE;
                    end else if (!beat_q[OB]) begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = DM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DM_IDLE;
            line_q  <= '0;
            scan_q  <= '0;
            beat_q  <= '0;
            rtag_q  <= '0;
            flush_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            scan_q  <= scan_d;
            beat_q  <= beat_d;
            rtag_q  <= rtag_d;
            flush_q <= flush_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (d_we) data_q[d_widx] <= d_wdata;
    end

    // Load and store in the same cycle is a core bug; the FSM treats it as a store.
    a_no_rd_wr: assert property (@(posedge clk) disable iff (rst) !(read_enable && we_eff));

endmodule

// File: tb/tb_holy_dm_cache.sv
module tb_holy_dm_cache;
    import holy_core_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address, write_data, read_data;
    logic        read_enable, write_enable, cache_stall, flush_req, flush_done, axi_error;
    logic [3:0]  byte_enable;
    holy_dm_cache_state_t cache_state;

    axi_if axi ();

    holy_dm_cache #(.NUM_LINES(4), .LINE_WORDS(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .address      (address),
        .write_data   (write_data),
        .read_enable  (read_enable),
        .write_enable (write_enable),
        .byte_enable  (byte_enable),
        .read_data    (read_data),
        .cache_stall  (cache_stall),
        .flush_req    (flush_req),
        .flush_done   (flush_done),
        .axi_error    (axi_error),
        .axi          (axi),
        .cache_state  (cache_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int aw_hs = 0, ar_hs = 0, fd_cnt = 0;

    always @(posedge clk) begin
        if (!rst) begin
            if (axi.awvalid && axi.awready) aw_hs <= aw_hs + 1;
            if (axi.arvalid && axi.arready) ar_hs <= ar_hs + 1;
            if (flush_done)                 fd_cnt <= fd_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Slave side of one refill: AR handshake then 32 zero-wait beats of base+i.
    task automatic rd_burst(input logic [31:0] exp_addr, input logic [31:0] base);
        int n = 0;
        while (!axi.arvalid && n < 50) begin @(negedge clk); #1; n++; end
        chk("arvalid", 32'(axi.arvalid), 32'd1);
        chk("araddr", axi.araddr, exp_addr);
        chk("arlen", 32'(axi.arlen), 32'd31);
        axi.arready = 1'b1;
        @(negedge clk);
        axi.arready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            axi.rvalid = 1'b1;
            axi.rdata  = base + 32'(i);
            axi.rlast  = (i == 31);
            @(negedge clk);
        end
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
        #1;
    endtask

    // Slave side of one write-back: AW, 32 W beats (optionally wready toggling),
    // then B with the given response. Expected beat i is base+i except sp_beat.
    task automatic wr_burst(input logic [31:0] exp_addr, input logic [31:0] base,
                            input int sp_beat, input logic [31:0] sp_val,
                            input bit toggle, input logic [1:0] bresp);
        int n = 0;
        int beat = 0;
        while (!axi.awvalid && n < 50) begin @(negedge clk); #1; n++; end
        chk("awvalid", 32'(axi.awvalid), 32'd1);
        chk("awaddr", axi.awaddr, exp_addr);
        chk("awlen", 32'(axi.awlen), 32'd31);
        axi.awready = 1'b1;
        @(negedge clk);
        axi.awready = 1'b0;
        n = 0;
        while (beat < 32 && n < 200) begin
            axi.wready = toggle ? n[0] : 1'b1;
            #1;
            if (axi.wready && axi.wvalid) begin
                chk("wdata", axi.wdata, (beat == sp_beat) ? sp_val : base + 32'(beat));
                chk("wlast", 32'(axi.wlast), 32'(beat == 31));
                beat++;
            end
            n++;
            @(negedge clk);
        end
        axi.wready = 1'b0;
        chk("wbeats", 32'(beat), 32'd32);
        axi.bvalid = 1'b1;
        axi.bresp  = bresp;
        n = 0;
        #1;
        while (!axi.bready && n < 20) begin @(negedge clk); #1; n++; end
        chk("bready", 32'(axi.bready), 32'd1);
        @(negedge clk);
        axi.bvalid = 1'b0;
        axi.bresp  = 2'b00;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        address = '0; write_data = '0; read_enable = 1'b0; write_enable = 1'b0;
        byte_enable = '0; flush_req = 1'b0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = '0; axi.bid = '0;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rlast = 1'b0;
        axi.rresp = '0; axi.rid = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_stall", 32'(cache_stall), 32'd0);
        chk("rst_rdata", read_data, 32'd0);
        chk("rst_flush_done", 32'(flush_done), 32'd0);
        chk("rst_axi_error", 32'(axi_error), 32'd0);
        chk("rst_valids", {27'd0, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 32'd0);
        chk("rst_state", 32'(cache_state), 32'(DM_IDLE));
        @(negedge clk);
        rst = 1'b0;

        // Cold read miss of 0x104 (index 2, offset 1).
        @(negedge clk);
        address = 32'h104; read_enable = 1'b1;
        #1;
        chk("miss_stall_comb", 32'(cache_stall), 32'd1);
        rd_burst(32'h100, 32'h1000_0000);
        chk("cold_rdata", read_data, 32'h1000_0001);
        chk("cold_stall_drop", 32'(cache_stall), 32'd0);
        chk("cold_no_aw", 32'(aw_hs), 32'd0);

        // Store hit with partial byte mask, then read back.
        read_enable = 1'b0;
        write_enable = 1'b1; write_data = 32'hAAAA_BBBB; byte_enable = 4'b0011;
        #1;
        chk("wr_hit_stall", 32'(cache_stall), 32'd0);
        @(negedge clk);
        write_enable = 1'b0; read_enable = 1'b1;
        #1;
        chk("wr_merge_rdata", read_data, 32'h1000_BBBB);
        chk("wr_no_axi", 32'(aw_hs + ar_hs), 32'd1);

        // Different index (1): refill only, line 2 untouched.
        @(negedge clk);
        address = 32'h84;
        #1;
        rd_burst(32'h80, 32'h2000_0000);
        chk("idx1_rdata", read_data, 32'h2000_0001);
        chk("idx1_no_aw", 32'(aw_hs), 32'd0);
        address = 32'h104;
        #1;
        chk("reread_hit", read_data, 32'h1000_BBBB);
        chk("reread_stall", 32'(cache_stall), 32'd0);

        // Flush: only line 2 is dirty.
        @(negedge clk);
        read_enable = 1'b0; flush_req = 1'b1;
        #1;
        chk("flush_stall", 32'(cache_stall), 32'd1);
        wr_burst(32'h100, 32'h1000_0000, 1, 32'h1000_BBBB, 1'b0, 2'b00);
        n = 0;
        #1;
        while (!flush_done && n < 20) begin @(negedge clk); #1; n++; end
        chk("flush_done_seen", 32'(flush_done), 32'd1);
        flush_req = 1'b0;
        @(negedge clk);
        #1;
        chk("flush_pulses", 32'(fd_cnt), 32'd1);
        chk("flush_aw_count", 32'(aw_hs), 32'd1);
        chk("flush_idle", 32'(cache_state), 32'(DM_IDLE));
        chk("flush_no_err", 32'(axi_error), 32'd0);

        // Conflicting miss on index 2 after flush: line is clean, no write-back.
        address = 32'h304; read_enable = 1'b1;
        #1;
        rd_burst(32'h300, 32'h3000_0000);
        chk("conflict_rdata", read_data, 32'h3000_0001);
        chk("conflict_no_wb", 32'(aw_hs), 32'd1);

        // Dirty the line again, then evict it under wready backpressure with SLVERR.
        read_enable = 1'b0;
        address = 32'h308; write_enable = 1'b1; write_data = 32'hDEAD_BEEF; byte_enable = 4'hF;
        @(negedge clk);
        write_enable = 1'b0;
        address = 32'h104; read_enable = 1'b1;
        #1;
        chk("dirty_miss_stall", 32'(cache_stall), 32'd1);
        wr_burst(32'h300, 32'h3000_0000, 2, 32'hDEAD_BEEF, 1'b1, 2'b10);
        #1;
        chk("bresp_err", 32'(axi_error), 32'd1);
        rd_burst(32'h100, 32'h4000_0000);
        chk("evict_rdata", read_data, 32'h4000_0001);
        chk("evict_err_sticky", 32'(axi_error), 32'd1);
        chk("evict_counts", {aw_hs[15:0], ar_hs[15:0]}, {16'd2, 16'd4});

        // Reset clears valid bits and the error flag.
        read_enable = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst2_err", 32'(axi_error), 32'd0);
        chk("rst2_state", 32'(cache_state), 32'(DM_IDLE));
        read_enable = 1'b1;
        #1;
        chk("rst2_miss", 32'(cache_stall), 32'd1);
        chk("rst2_rdata", read_data, 32'd0);
        read_enable = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/holy_dm_cache.md
# holy_dm_cache

Multi-line, write-back, direct-mapped data cache for the Holy Core. It sits between the core's load/store interface and the AXI arbiter. NUM_LINES independent lines each hold their own tag, valid and dirty state, so a miss refills or evicts only one line of LINE_WORDS words rather than the whole cache. It also adds an explicit flush mode that writes back every dirty line, and a sticky AXI error flag.

## Interface
- NUM_LINES, 4, number of lines; power of two, ≥1
- LINE_WORDS, 32, 32-bit words per line; power of two, 2..256 (AXI len limit)
- clk  in  1  sole clock, for core side and AXI side
- rst  in  1  synchronous, active-high reset
- address  in  32  byte address from the core
- write_data  in  32  store data
- read_enable  in  1  load request
- write_enable  in  1  store request
- byte_enable  in  4  store byte lanes
- read_data  out  32  load data; combinational on hit, else 0
- cache_stall  out  1  core must hold its request while high
- flush_req  in  1  level; request a write-back of all dirty lines
- flush_done  out  1  one-cycle pulse when a flush completes
- axi_error  out  1  sticky; set on a bad bresp or a burst-length mismatch; cleared by rst
- axi  axi_if.master  –  AXI4 master port to the arbiter
- cache_state  out  holy_dm_cache_state_t  current FSM state, for the arbiter

## Operation
- Address split: offset = address[OB+1:2] with OB = log2(LINE_WORDS); index = next log2(NUM_LINES) bits; tag = the remaining upper bits.
- Per-line storage: tag, valid, dirty. Valid and dirty reset to 0; the data array is not reset.
- Hit: index line is valid and its tag equals the request tag.
- Effective write: we_eff = write_enable & |byte_enable.
- read_enable and we_eff together is illegal: an assertion fires and the access is treated as a write.
- States: IDLE, WB_REQ, WB_DATA, WB_RESP, RF_REQ, RF_DATA, FLUSH_SCAN.
- IDLE, hit read: read_data = word at [index][offset].
- IDLE, hit write: bytes merged under the byte_enable mask at the clock edge; line dirty set.
- IDLE, miss (read or we_eff):
  - victim dirty → WB_REQ;
  - victim clean → RF_REQ.
- IDLE, flush_req with no read/write pending → FLUSH_SCAN with scan pointer = 0. A pending access takes priority over a flush.
- FLUSH_SCAN, at each pointer value:
  - line valid & dirty → write-back;
  - otherwise pointer+1;
  - past the last line → flush_done pulse, then IDLE.
- WB_REQ: awvalid=1, awaddr = {victim tag, index, 0, 2'b00}. On awready → WB_DATA.
- WB_DATA: wvalid=1, wdata = victim[beat]. Beat advances on wready. wlast on beat LINE_WORDS-1, then → WB_RESP.
- WB_RESP: bready=1. On bvalid:
  - clear dirty;
  - bresp≠0 → set axi_error;
  - then → RF_REQ, or back to FLUSH_SCAN at pointer+1 when flushing.
- RF_REQ: arvalid=1, araddr = {request tag, index, 0, 2'b00}. On arready → RF_DATA.
- RF_DATA: rready=1. Each rvalid beat writes word[beat], beat+1. On rlast:
  - beat count = LINE_WORDS → tag updated, valid=1, dirty=0;
  - else → valid=0, axi_error set;
  - then → IDLE.
- Fixed AXI fields: awlen/arlen = LINE_WORDS-1, size 3'b010, burst INCR, ids 0, wstrb 4'hF.
- All valid/ready outputs are 0 in IDLE and FLUSH_SCAN.

## Timing
- Reset values: cache_stall=0, read_data=0, flush_done=0, axi_error=0, all AXI valid/ready=0, cache_state=IDLE.
- Hit read: zero latency. Hit write: committed at the next edge. cache_stall stays 0 in both cases.
- cache_stall = (state≠IDLE) | (~hit & (read_enable|we_eff)) | (state==IDLE & flush_req & no access pending).
- The stall is combinational in the miss cycle.
- Clean miss, with zero-wait slaves: 1 (AR) + LINE_WORDS beats; stall drops in the first IDLE cycle after rlast.
- Dirty miss adds 1 (AW) + LINE_WORDS beats + 1 (B) cycles.
- Backpressure: when wready or rvalid is low, the beat pointer holds, and wdata/awaddr/araddr are held stable.
- rst asserted mid-burst: the next edge forces IDLE and clears all valid/dirty bits; outstanding AXI transactions are abandoned.

## Structure
- holy_core_pkg gains holy_dm_cache_state_t. The existing cache_state_t is left untouched.
- One sub-module, holy_dm_cache_meta: the tag/valid/dirty array with an asynchronous read port and a single write port.
- The data array stays inline.

## Test plan
Defaults apply: index = address[8:7], tag = address[31:9].
- Cold read of 0x0000_0104, slave returns 0x1000_0000+i on beat i → araddr 0x0000_0100, arlen 31, read_data 0x1000_0001, no AW traffic.
- Write 0xAAAA_BBBB to 0x104 with byte_enable 4'b0011, then read 0x104 → 0x1000_BBBB, no AXI traffic.
- Read 0x0000_0304 (conflicts on index 2):
  - AW at 0x0000_0100 with 32 beats, beat 1 = 0x1000_BBBB, wlast on beat 31;
  - then AR at 0x0000_0300.
- Read 0x0000_0084 after the first scenario → AR at 0x0000_0080 only; a re-read of 0x104 hits.
- Flush with line 2 dirty and line 1 clean → exactly one AW burst (at 0x100), one flush_done pulse; a later conflicting miss issues no write-back.
- wready toggling every cycle plus bresp=2'b10 → correct data on all 32 beats, axi_error=1, refill still completes.
